// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with shadow/display registers for
// tear-free updates, ghost blanking, leading-zero suppression and pin polarity.
module seg7_scan_driver #(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned DIV        = 100000,
  parameter int unsigned GHOST      = 2,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NDIG-1:0]       digits,
  input  logic [NDIG-1:0]         dp_in,
  input  logic [NDIG-1:0]         blank,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NDIG-1:0]         an,
  output logic [$clog2(NDIG)-1:0] scan_idx,
  output logic                    frame
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = $clog2(NDIG);
  localparam int unsigned SW = 6 * NDIG;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   shadow_q, shadow_d;
  logic [SW-1:0]   display_q, display_d;
  logic            frame_q;
  logic [7:0]      seg_q, seg_d;
  logic [NDIG-1:0] an_q, an_d;

  logic            wrap, last, boundary, ghost, dark, all_zero;
  logic [SW-1:0]   in_vec;
  logic [4*NDIG-1:0] disp_dig;
  logic [NDIG-1:0] disp_dp, disp_bl, lz_dark;
  logic [3:0]      cur_nib;
  logic [7:0]      seg_raw;
  logic [NDIG-1:0] an_raw;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] p;
    unique case (v)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110;
      4'hD: p = 7'b0111101;
      4'hE: p = 7'b1001111;
      4'hF: p = 7'b1000111;
    endcase
    return p;
  endfunction

  // Scan timing and register update.
  always_comb begin
    in_vec   = {digits, dp_in, blank};
    wrap     = (cnt_q == CW'(DIV - 1));
    last     = (idx_q == IW'(NDIG - 1));
    boundary = wrap && last;
    cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (wrap) idx_d = last ? '0 : idx_q + IW'(1);
    shadow_d  = load ? in_vec : shadow_q;
    // A load coinciding with the boundary bypasses the stale shadow.
    display_d = boundary ? (load ? in_vec : shadow_q) : display_q;
  end

  // Leading-zero scan from the most significant digit downwards.
  always_comb begin
    disp_dig = display_q[SW-1 -: 4*NDIG];
    disp_dp  = display_q[2*NDIG-1 -: NDIG];
    disp_bl  = display_q[NDIG-1:0];
    all_zero = 1'b1;
    lz_dark  = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      all_zero   = all_zero && (disp_dig[4*i +: 4] == 4'h0);
      lz_dark[i] = lz_en && all_zero && (i != 0);
    end
  end

  always_comb begin
    cur_nib = disp_dig[{idx_q, 2'b00} +: 4];
    dark    = disp_bl[idx_q] || lz_dark[idx_q];
    ghost   = (cnt_q < CW'(GHOST));
    seg_raw = {dark ? 7'b0 : seg7(cur_nib), disp_dp[idx_q] && !disp_bl[idx_q]};
    an_raw  = '0;
    an_raw[idx_q] = 1'b1;
    if (ghost) begin
      seg_raw = '0;
      an_raw  = '0;
    end
    seg_d = seg_raw ^ {8{ACTIVE_LOW}};
    an_d  = an_raw ^ {NDIG{ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      display_q <= '0;
      frame_q   <= 1'b0;
      seg_q     <= {8{ACTIVE_LOW}};
      an_q      <= {NDIG{ACTIVE_LOW}};
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      frame_q   <= boundary;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign scan_idx = idx_q;
  assign frame    = frame_q;

endmodule
